dmem_responder: RTL and testbench

Memory-side responder for the pipeline's data-memory port. It accepts one load/store request at a time over a valid/ready handshake and models a configurable access latency. It performs byte, halfword and word accesses with lane alignment and sign or zero extension, then returns a held response until the pipeline consumes it. It sits between the MEM stage and a word-organised data array, and replaces the zero-latency combinational memory so the hazard logic can be exercised under stalls.

---
 rtl/dmem_pkg.sv | 42 ++++
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder_lane_align.sv | 47 ++++
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: access sizes,
// FSM states, the latched request record and the access-legality check.
package dmem_pkg;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    size_e       size;
    logic        is_unsigned;
  } req_t;

  // limit is the first illegal byte address; one extra bit so 4*DEPTH never wraps.
  function automatic logic access_err(input size_e size, input logic [31:0] addr,
                                      input logic [32:0] limit);
    logic bad_align;
    case (size)
      SZ_BYTE: bad_align = 1'b0;
      SZ_HALF: bad_align = addr[0];
      SZ_WORD: bad_align = |addr[1:0];
      default: bad_align = 1'b1;
    endcase
    return bad_align || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the
// data-memory responder (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering: store byte enables and replicated data, plus load
// lane extraction with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  input  logic        unsigned_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_ext_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be_o        = 4'b0000;
    wdata_rep_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep_o = {2{wdata_i[15:0]}};
      end
      SZ_WORD: be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
  end

  assign rbyte = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign rhalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    case (size_i)
      SZ_BYTE: rdata_ext_o = {{24{rbyte[7] & ~unsigned_i}}, rbyte};
      SZ_HALF: rdata_ext_o = {{16{rhalf[15] & ~unsigned_i}}, rhalf};
      default: rdata_ext_o = rword_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, configurable latency,
// byte-lane word array and a held response until the pipeline consumes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  dmem_if.slave bus
);

  localparam int               IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0]      ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d, in_req, cur_req;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             enter_resp;
  logic             cur_err;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wdata_rep, rword, rdata_ext;

  always_comb begin
    in_req             = '0;
    in_req.write       = bus.req_write;
    in_req.addr        = bus.req_addr;
    in_req.wdata       = bus.req_wdata;
    in_req.size        = size_e'(bus.req_size);
    in_req.is_unsigned = bus.req_unsigned;
  end

  // With zero wait the access happens on the acceptance edge, so IDLE uses the live request.
  assign cur_req = (state_q == IDLE) ? in_req : req_q;
  assign req_d   = (state_q == IDLE && bus.req_valid) ? in_req : req_q;
  assign cur_err = access_err(cur_req.size, cur_req.addr, ADDR_LIMIT);
  assign idx     = cur_req.addr[IDX_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.busy      = (state_q == WAIT) || (state_q == RESP);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

  // Single-cycle strobe: gating with rst_n keeps a store held in reset out of the array.
  assign enter_resp = (state_d == RESP) && (state_q != RESP) && rst_n;

  dmem_lane_align u_align (
    .size_i      (cur_req.size),
    .addr_lo_i   (cur_req.addr[1:0]),
    .wdata_i     (cur_req.wdata),
    .rword_i     (rword),
    .unsigned_i  (cur_req.is_unsigned),
    .be_o        (be),
    .wdata_rep_o (wdata_rep),
    .rdata_ext_o (rdata_ext)
  );

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (enter_resp && cur_req.write && !cur_err && be[gi]) begin
          lane_mem[idx] <= wdata_rep[gi*8 +: 8];
        end
      end

      assign rword[gi*8 +: 8] = lane_mem[idx];
    end
  endgenerate

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = cur_err;
      rdata_d = (cur_err || cur_req.write) ? '0 : rdata_ext;
    end else if (state_q == RESP && bus.rsp_ready) begin
      err_d   = 1'b0;
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a byte-addressed reference model tracks DUT A
// every cycle; DUT B (longer latency) covers reset in the middle of a store.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int WAIT_A = 1;
  localparam int WAIT_B = 4;
  localparam int DEPTH  = 256;

  logic clk     = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  always #5 clk = ~clk;

  dmem_if bus_a ();
  dmem_if bus_b ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk (clk), .rst_n (rst_n_a), .bus (bus_a)
  );
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_B)) dut_b (
    .clk (clk), .rst_n (rst_n_b), .bus (bus_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // Reference memory: plain byte array, little-endian, no lanes.
  logic [7:0] ref_mem [0:4*DEPTH-1];

  function automatic logic [32:0] model_access(input logic wr, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [1:0] size,
                                               input logic uns);
    int          nbytes;
    logic [31:0] v;
    logic        err;
    nbytes = 1 << size;
    err    = (size == 2'd3) || (addr % nbytes != 0) || (addr >= 4 * DEPTH);
    v      = 32'h0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < nbytes; i++) ref_mem[addr + i] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
        if (nbytes < 4 && !uns && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
      end
    end
    return {err, v};
  endfunction

  logic        m_en = 1'b0;
  logic        m_busy, m_resp;
  int          m_wait;
  logic [32:0] m_res;

  // Abstract timing: response appears WAIT_A edges after acceptance, held until consumed.
  always @(posedge clk) begin
    if (!m_en) begin
      m_busy <= 1'b0;
      m_resp <= 1'b0;
      m_wait <= 0;
    end else if (!m_busy) begin
      if (bus_a.req_valid) begin
        m_res  <= model_access(bus_a.req_write, bus_a.req_addr, bus_a.req_wdata,
                               bus_a.req_size, bus_a.req_unsigned);
        m_busy <= 1'b1;
        m_wait <= WAIT_A;
        m_resp <= (WAIT_A == 0);
      end
    end else if (!m_resp) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) m_resp <= 1'b1;
    end else if (bus_a.rsp_ready) begin
      m_busy <= 1'b0;
      m_resp <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      chk("a_req_ready", 32'(bus_a.req_ready), 32'(!m_busy));
      chk("a_busy", 32'(bus_a.busy), 32'(m_busy));
      chk("a_rsp_valid", 32'(bus_a.rsp_valid), 32'(m_resp));
      if (m_resp) begin
        chk("a_rsp_rdata", bus_a.rsp_rdata, m_res[31:0]);
        chk("a_rsp_err", 32'(bus_a.rsp_err), 32'(m_res[32]));
      end
    end
  end

  function automatic logic [31:0] obs(input logic sel_b, input int what);
    case (what)
      0:       return sel_b ? 32'(bus_b.req_ready) : 32'(bus_a.req_ready);
      1:       return sel_b ? 32'(bus_b.busy)      : 32'(bus_a.busy);
      2:       return sel_b ? 32'(bus_b.rsp_valid) : 32'(bus_a.rsp_valid);
      3:       return sel_b ? bus_b.rsp_rdata      : bus_a.rsp_rdata;
      default: return sel_b ? 32'(bus_b.rsp_err)   : 32'(bus_a.rsp_err);
    endcase
  endfunction

  task automatic drive_req(input logic sel_b, input logic vld, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns);
    if (sel_b) begin
      bus_b.req_valid = vld; bus_b.req_write = wr; bus_b.req_addr = addr;
      bus_b.req_wdata = wdata; bus_b.req_size = size; bus_b.req_unsigned = uns;
    end else begin
      bus_a.req_valid = vld; bus_a.req_write = wr; bus_a.req_addr = addr;
      bus_a.req_wdata = wdata; bus_a.req_size = size; bus_a.req_unsigned = uns;
    end
  endtask

  task automatic set_rsp_ready(input logic sel_b, input logic v);
    if (sel_b) bus_b.rsp_ready = v;
    else       bus_a.rsp_ready = v;
  endtask

  // Called and returns on a falling edge; lat counts the acceptance cycle as 1.
  task automatic txn(input logic sel_b, input string tag, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size,
                     input logic uns, input int hold,
                     output logic [31:0] rdata, output logic err, output int lat);
    int n;
    drive_req(sel_b, 1'b1, wr, addr, wdata, size, uns);
    n = 0;
    while (obs(sel_b, 0) == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, obs(sel_b, 0), 32'h1);
    @(negedge clk);
    drive_req(sel_b, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    lat = 1;
    while (obs(sel_b, 2) == 0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_rsp_seen"}, obs(sel_b, 2), 32'h1);
    rdata = obs(sel_b, 3);
    err   = obs(sel_b, 4)[0];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, obs(sel_b, 2), 32'h1);
      chk({tag, "_hold_busy"}, obs(sel_b, 1), 32'h1);
      chk({tag, "_hold_ready"}, obs(sel_b, 0), 32'h0);
      chk({tag, "_hold_rdata"}, obs(sel_b, 3), rdata);
    end
    set_rsp_ready(sel_b, 1'b1);
    @(negedge clk);
    set_rsp_ready(sel_b, 1'b0);
    $display("txn %s wr=%0d addr=%08h wdata=%08h size=%0d uns=%0d rdata=%08h err=%0d lat=%0d",
             tag, wr, addr, wdata, size, uns, rdata, err, lat);
  endtask

  task automatic chk_reset_outputs(input logic sel_b, input string tag);
    chk({tag, "_req_ready"}, obs(sel_b, 0), 32'h1);
    chk({tag, "_busy"}, obs(sel_b, 1), 32'h0);
    chk({tag, "_rsp_valid"}, obs(sel_b, 2), 32'h0);
    chk({tag, "_rsp_rdata"}, obs(sel_b, 3), 32'h0);
    chk({tag, "_rsp_err"}, obs(sel_b, 4), 32'h0);
  endtask

  logic [31:0] r;
  logic        e;
  int          l;

  initial begin
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    set_rsp_ready(1'b0, 1'b0);
    set_rsp_ready(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk_reset_outputs(1'b0, "rst_a");
    chk_reset_outputs(1'b1, "rst_b");
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    m_en    = 1'b1;
    @(negedge clk);

    txn(1'b0, "st_w_10", 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, r, e, l);
    chk("st_w_10_err", 32'(e), 32'h0);
    chk("st_w_10_lat", 32'(l), 32'd2);
    txn(1'b0, "ld_w_10", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, r, e, l);
    chk("ld_w_10_rdata", r, 32'hDEADBEEF);
    chk("ld_w_10_lat", 32'(l), 32'd2);

    txn(1'b0, "st_w_20", 1'b1, 32'h20, 32'h0, 2'd2, 1'b0, 0, r, e, l);
    txn(1'b0, "st_b_21", 1'b1, 32'h21, 32'h80, 2'd0, 1'b0, 0, r, e, l);
    txn(1'b0, "ld_b_21_s", 1'b0, 32'h21, 32'h0, 2'd0, 1'b0, 0, r, e, l);
    chk("ld_b_21_s_rdata", r, 32'hFFFFFF80);
    txn(1'b0, "ld_b_21_u", 1'b0, 32'h21, 32'h0, 2'd0, 1'b1, 0, r, e, l);
    chk("ld_b_21_u_rdata", r, 32'h00000080);
    txn(1'b0, "ld_w_20", 1'b0, 32'h20, 32'h0, 2'd2, 1'b1, 0, r, e, l);
    chk("ld_w_20_rdata", r, 32'h00008000);
    txn(1'b0, "ld_h_20_s", 1'b0, 32'h20, 32'h0, 2'd1, 1'b0, 0, r, e, l);
    chk("ld_h_20_s_rdata", r, 32'hFFFF8000);

    txn(1'b0, "st_h_13", 1'b1, 32'h13, 32'h1234, 2'd1, 1'b0, 0, r, e, l);
    chk("st_h_13_err", 32'(e), 32'h1);
    chk("st_h_13_rdata", r, 32'h0);
    txn(1'b0, "ld_w_10b", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, r, e, l);
    chk("ld_w_10b_rdata", r, 32'hDEADBEEF);
    txn(1'b0, "ld_w_400", 1'b0, 32'h400, 32'h0, 2'd2, 1'b0, 0, r, e, l);
    chk("ld_w_400_err", 32'(e), 32'h1);
    txn(1'b0, "ld_rsvd", 1'b0, 32'h10, 32'h0, 2'd3, 1'b0, 0, r, e, l);
    chk("ld_rsvd_err", 32'(e), 32'h1);
    txn(1'b0, "ld_w_12", 1'b0, 32'h12, 32'h0, 2'd2, 1'b0, 0, r, e, l);
    chk("ld_w_12_err", 32'(e), 32'h1);

    txn(1'b0, "st_h_12", 1'b1, 32'h12, 32'hBEEF, 2'd1, 1'b0, 0, r, e, l);
    txn(1'b0, "ld_w_10c", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, r, e, l);
    chk("ld_w_10c_rdata", r, 32'hBEEFBEEF);
    txn(1'b0, "ld_b_13_u", 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0, r, e, l);
    chk("ld_b_13_u_rdata", r, 32'h000000BE);

    txn(1'b0, "st_w_30", 1'b1, 32'h30, 32'hA5A5A5A5, 2'd2, 1'b0, 0, r, e, l);
    txn(1'b0, "st_b_30_hold", 1'b1, 32'h30, 32'h11, 2'd0, 1'b0, 5, r, e, l);
    txn(1'b0, "ld_w_30", 1'b0, 32'h30, 32'h0, 2'd2, 1'b0, 0, r, e, l);
    chk("ld_w_30_rdata", r, 32'hA5A5A511);

    txn(1'b0, "st_b_3ff", 1'b1, 32'h3FF, 32'h7F, 2'd0, 1'b0, 0, r, e, l);
    chk("st_b_3ff_err", 32'(e), 32'h0);
    txn(1'b0, "ld_b_3ff", 1'b0, 32'h3FF, 32'h0, 2'd0, 1'b0, 0, r, e, l);
    chk("ld_b_3ff_rdata", r, 32'h0000007F);
    txn(1'b0, "ld_b_400", 1'b0, 32'h400, 32'h0, 2'd0, 1'b0, 0, r, e, l);
    chk("ld_b_400_err", 32'(e), 32'h1);

    txn(1'b1, "b_st_w_40", 1'b1, 32'h40, 32'h12345678, 2'd2, 1'b0, 0, r, e, l);
    chk("b_st_w_40_lat", 32'(l), 32'd5);
    drive_req(1'b1, 1'b1, 1'b1, 32'h40, 32'hAAAA5555, 2'd2, 1'b0);
    chk("b_abort_ready", obs(1'b1, 0), 32'h1);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    chk("b_abort_busy", obs(1'b1, 1), 32'h1);
    rst_n_b = 1'b0;
    #1;
    chk_reset_outputs(1'b1, "b_midrst");
    @(negedge clk);
    chk_reset_outputs(1'b1, "b_inrst");
    rst_n_b = 1'b1;
    @(negedge clk);
    txn(1'b1, "b_ld_w_40", 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0, r, e, l);
    chk("b_ld_w_40_rdata", r, 32'h12345678);
    chk("b_ld_w_40_lat", 32'(l), 32'd5);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
